// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline controller: stage indices, scoreboard entry layout, control modes.
// Scoreboard entry is {valid, wb_en, ld, rd_addr}; flag offsets are relative to the top of rd_addr.
package pipe_ctrl_pkg;

  localparam int unsigned STG_IFID   = 0;
  localparam int unsigned STG_IDEX   = 1;
  localparam int unsigned STG_EXWB   = 2;

  localparam int unsigned BUSY_W_DEF = 4;

  localparam int unsigned SB_FLAG_W    = 3;
  localparam int unsigned SB_LD_OFS    = 0;
  localparam int unsigned SB_WB_OFS    = 1;
  localparam int unsigned SB_VALID_OFS = 2;

  typedef enum logic [1:0] {
    MODE_RUN,
    MODE_HAZARD,
    MODE_BUSY,
    MODE_FLUSH
  } mode_e;

endpackage

// File: rtl/pipe_ctrl_sb_entry.sv
// One pipeline-register slice of the valid/scoreboard shift chain.
// Flush and bubble both clear the entry; otherwise it holds unless enabled.
module pipe_sb_entry
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned ENT_W = 4 + SB_FLAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             bubble,
  input  logic             flush,
  input  logic [ENT_W-1:0] d,
  output logic [ENT_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      q <= '0;
    end else if (en) begin
      q <= bubble ? '0 : d;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stage valids/enables, RAW scoreboard, EX busy counter, branch flush/redirect.
// Define PIPE_CTRL_FWD_EN for a forwarding datapath (load-use interlock only).
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned STAGES     = 3,
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned BUSY_W     = BUSY_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs_addr_i,
  input  logic [REG_ADDR_W-1:0] id_rd_addr_i,
  input  logic                  id_use_rs_i,
  input  logic                  id_use_rd_i,
  input  logic                  id_wb_en_i,
  input  logic                  id_ld_i,
  input  logic                  ex_start_i,
  input  logic [BUSY_W-1:0]     ex_cycles_i,
  input  logic                  branch_en_i,
  input  logic [ADDR_W-1:0]     branch_addr_i,
  output logic [STAGES-1:0]     stage_valid_o,
  output logic [STAGES-1:0]     stage_en_o,
  output logic                  stall_if_o,
  output logic                  hazard_o,
  output logic                  flush_o,
  output logic                  redirect_o,
  output logic [ADDR_W-1:0]     redirect_addr_o
);

  localparam int unsigned ENT_W  = REG_ADDR_W + SB_FLAG_W;
  localparam int unsigned V_BIT  = REG_ADDR_W + SB_VALID_OFS;
  localparam int unsigned WB_BIT = REG_ADDR_W + SB_WB_OFS;
  localparam int unsigned LD_BIT = REG_ADDR_W + SB_LD_OFS;

  logic [ENT_W-1:0]  sb_d [STAGES];
  logic [ENT_W-1:0]  sb_q [STAGES];
  logic [STAGES-1:0] valid;
  logic [STAGES-1:0] en;
  logic [STAGES-1:0] bubble;
  logic [STAGES-1:0] flush;
  logic [BUSY_W-1:0] cnt;
  logic              busy;
  logic              take;
  logic              raw;
  logic              load_cnt;
  mode_e             mode;

  assign busy     = (cnt != '0);
  assign take     = branch_en_i && valid[STG_IDEX] && !busy;
  assign load_cnt = !take && !busy && valid[STG_IDEX] && ex_start_i && (ex_cycles_i != '0);

  always_comb begin
    raw = 1'b0;
`ifdef PIPE_CTRL_FWD_EN
    if (valid[STG_IFID] && sb_q[STG_IDEX][V_BIT] && sb_q[STG_IDEX][LD_BIT] &&
        ((id_use_rs_i && (sb_q[STG_IDEX][REG_ADDR_W-1:0] == id_rs_addr_i)) ||
         (id_use_rd_i && (sb_q[STG_IDEX][REG_ADDR_W-1:0] == id_rd_addr_i)))) begin
      raw = 1'b1;
    end
`else
    // The WB stage writes through the register file, so it is excluded from the compare.
    for (int unsigned k = STG_IDEX; k <= STAGES - 2; k++) begin
      if (valid[STG_IFID] && sb_q[k][V_BIT] && sb_q[k][WB_BIT] &&
          ((id_use_rs_i && (sb_q[k][REG_ADDR_W-1:0] == id_rs_addr_i)) ||
           (id_use_rd_i && (sb_q[k][REG_ADDR_W-1:0] == id_rd_addr_i)))) begin
        raw = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    mode   = MODE_RUN;
    en     = '1;
    bubble = '0;
    flush  = '0;
    if (take) begin
      mode = MODE_FLUSH;
    end else if (busy) begin
      mode = MODE_BUSY;
    end else if (raw) begin
      mode = MODE_HAZARD;
    end
    case (mode)
      MODE_FLUSH: begin
        flush[STG_IFID] = 1'b1;
        flush[STG_IDEX] = 1'b1;
      end
      MODE_BUSY: begin
        en[STG_IFID]     = 1'b0;
        en[STG_IDEX]     = 1'b0;
        bubble[STG_EXWB] = 1'b1;
      end
      MODE_HAZARD: begin
        en[STG_IFID]     = 1'b0;
        bubble[STG_IDEX] = 1'b1;
      end
      default: ;
    endcase
  end

  // Stage 0 only tracks validity; the ID decode fields enter the chain at stage 1.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == STG_IFID) begin : g_ifid
      assign sb_d[k] = {fetch_valid_i, 2'b00, {REG_ADDR_W{1'b0}}};
    end else if (k == STG_IDEX) begin : g_idex
      assign sb_d[k] = {valid[STG_IFID], id_wb_en_i, id_ld_i, id_rd_addr_i};
    end else begin : g_tail
      assign sb_d[k] = sb_q[k-1];
    end

    pipe_sb_entry #(.ENT_W(ENT_W)) u_entry (
      .clk    (clk),
      .rst    (rst),
      .en     (en[k]),
      .bubble (bubble[k]),
      .flush  (flush[k]),
      .d      (sb_d[k]),
      .q      (sb_q[k])
    );

    assign valid[k] = sb_q[k][V_BIT];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt             <= '0;
      flush_o         <= 1'b0;
      redirect_o      <= 1'b0;
      redirect_addr_o <= '0;
    end else begin
      flush_o    <= take;
      redirect_o <= take;
      if (take) begin
        redirect_addr_o <= branch_addr_i;
      end
      if (busy) begin
        cnt <= cnt - 1'b1;
      end else if (load_cnt) begin
        cnt <= ex_cycles_i;
      end
    end
  end

  assign stage_valid_o = valid;
  assign stage_en_o    = rst ? en : '0;
  assign stall_if_o    = rst && ((mode == MODE_BUSY) || (mode == MODE_HAZARD));
  assign hazard_o      = rst && raw && !take;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: table of per-cycle vectors plus hand-written hazard/branch/reset cases.
// Expectations follow PIPE_CTRL_FWD_EN when it is defined.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        fetch_valid_i;
  logic [3:0]  id_rs_addr_i;
  logic [3:0]  id_rd_addr_i;
  logic        id_use_rs_i;
  logic        id_use_rd_i;
  logic        id_wb_en_i;
  logic        id_ld_i;
  logic        ex_start_i;
  logic [3:0]  ex_cycles_i;
  logic        branch_en_i;
  logic [15:0] branch_addr_i;
  logic [2:0]  stage_valid_o;
  logic [2:0]  stage_en_o;
  logic        stall_if_o;
  logic        hazard_o;
  logic        flush_o;
  logic        redirect_o;
  logic [15:0] redirect_addr_o;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_addr [$];

  pipe_ctrl #(.STAGES(3), .REG_ADDR_W(4), .ADDR_W(16), .BUSY_W(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .fetch_valid_i   (fetch_valid_i),
    .id_rs_addr_i    (id_rs_addr_i),
    .id_rd_addr_i    (id_rd_addr_i),
    .id_use_rs_i     (id_use_rs_i),
    .id_use_rd_i     (id_use_rd_i),
    .id_wb_en_i      (id_wb_en_i),
    .id_ld_i         (id_ld_i),
    .ex_start_i      (ex_start_i),
    .ex_cycles_i     (ex_cycles_i),
    .branch_en_i     (branch_en_i),
    .branch_addr_i   (branch_addr_i),
    .stage_valid_o   (stage_valid_o),
    .stage_en_o      (stage_en_o),
    .stall_if_o      (stall_if_o),
    .hazard_o        (hazard_o),
    .flush_o         (flush_o),
    .redirect_o      (redirect_o),
    .redirect_addr_o (redirect_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst, fv, exs;
    logic [3:0]  cyc;
    logic        br;
    logic [15:0] baddr;
    logic [2:0]  ev, een;
    logic        est, ehz, efl, erd;
  } vec_t;

  vec_t tbl [22];

  function automatic vec_t row(input logic r, fv, exs, input logic [3:0] cyc, input logic br,
                               input logic [15:0] ba, input logic [2:0] ev, een,
                               input logic est, ehz, efl, erd);
    vec_t v;
    v.rst = r; v.fv = fv; v.exs = exs; v.cyc = cyc; v.br = br; v.baddr = ba;
    v.ev = ev; v.een = een; v.est = est; v.ehz = ehz; v.efl = efl; v.erd = erd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_redirect(input string name);
    if (redirect_o === 1'b1) begin
      if (exp_addr.size() == 0) chk({name, "_unexpected_redirect"}, 32'd1, 32'd0);
      else chk({name, "_redirect_addr"}, {16'h0, redirect_addr_o}, {16'h0, exp_addr.pop_front()});
    end
  endtask

  task automatic clear_inputs();
    fetch_valid_i = 1'b0; id_rs_addr_i = '0; id_rd_addr_i = '0; id_use_rs_i = 1'b0;
    id_use_rd_i = 1'b0; id_wb_en_i = 1'b0; id_ld_i = 1'b0; ex_start_i = 1'b0;
    ex_cycles_i = '0; branch_en_i = 1'b0; branch_addr_i = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    fetch_valid_i = 1'b1;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic raw_case(input logic [3:0] prd, input logic pld, input logic [3:0] crs, crd,
                          input logic urs, urd, input int exp_stall, input string nm);
    int n;
    do_reset();
    fetch_valid_i = 1'b1;
    tick();
    id_wb_en_i = 1'b1; id_ld_i = pld; id_rd_addr_i = prd;
    tick();
    id_wb_en_i = 1'b0; id_ld_i = 1'b0; id_rd_addr_i = crd; id_rs_addr_i = crs;
    id_use_rs_i = urs; id_use_rd_i = urd;
    #1;
    chk({nm, "_hazard"}, {31'h0, hazard_o}, {31'h0, (exp_stall > 0)});
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (stall_if_o !== 1'b1) break;
      n++;
      tick();
    end
    chk({nm, "_stall_cycles"}, n, exp_stall);
    if (exp_stall > 0) chk({nm, "_bubble_valid"}, {29'h0, stage_valid_o}, 32'h5);
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    fetch_valid_i = 1'b1;
    tick();
    tick();

    //             rst fv exs cyc br  baddr     ev      een     st hz fl rd
    tbl[0]  = row(0, 1, 0, 0, 0, 16'h0,    3'b000, 3'b000, 0, 0, 0, 0);
    tbl[1]  = row(1, 1, 0, 0, 0, 16'h0,    3'b000, 3'b111, 0, 0, 0, 0);
    tbl[2]  = row(1, 1, 0, 0, 0, 16'h0,    3'b001, 3'b111, 0, 0, 0, 0);
    tbl[3]  = row(1, 1, 0, 0, 0, 16'h0,    3'b011, 3'b111, 0, 0, 0, 0);
    tbl[4]  = row(1, 1, 0, 0, 0, 16'h0,    3'b111, 3'b111, 0, 0, 0, 0);
    tbl[5]  = row(1, 1, 0, 0, 0, 16'h0,    3'b111, 3'b111, 0, 0, 0, 0);
    tbl[6]  = row(1, 1, 1, 3, 0, 16'h0,    3'b111, 3'b111, 0, 0, 0, 0);
    tbl[7]  = row(1, 1, 0, 0, 0, 16'h0,    3'b111, 3'b100, 1, 0, 0, 0);
    tbl[8]  = row(1, 1, 0, 0, 0, 16'h0,    3'b011, 3'b100, 1, 0, 0, 0);
    tbl[9]  = row(1, 1, 0, 0, 0, 16'h0,    3'b011, 3'b100, 1, 0, 0, 0);
    tbl[10] = row(1, 1, 0, 0, 0, 16'h0,    3'b011, 3'b111, 0, 0, 0, 0);
    tbl[11] = row(1, 1, 0, 0, 0, 16'h0,    3'b111, 3'b111, 0, 0, 0, 0);
    tbl[12] = row(1, 1, 0, 0, 1, 16'h0040, 3'b111, 3'b111, 0, 0, 0, 0);
    tbl[13] = row(1, 1, 0, 0, 0, 16'h0,    3'b100, 3'b111, 0, 0, 1, 1);
    tbl[14] = row(1, 1, 0, 0, 0, 16'h0,    3'b001, 3'b111, 0, 0, 0, 0);
    tbl[15] = row(1, 1, 0, 0, 0, 16'h0,    3'b011, 3'b111, 0, 0, 0, 0);
    tbl[16] = row(1, 1, 1, 2, 0, 16'h0,    3'b111, 3'b111, 0, 0, 0, 0);
    tbl[17] = row(1, 1, 0, 0, 1, 16'h1234, 3'b111, 3'b100, 1, 0, 0, 0);
    tbl[18] = row(1, 1, 0, 0, 1, 16'h1234, 3'b011, 3'b100, 1, 0, 0, 0);
    tbl[19] = row(1, 1, 0, 0, 0, 16'h0,    3'b011, 3'b111, 0, 0, 0, 0);
    tbl[20] = row(1, 1, 1, 0, 0, 16'h0,    3'b111, 3'b111, 0, 0, 0, 0);
    tbl[21] = row(1, 1, 0, 0, 0, 16'h0,    3'b111, 3'b111, 0, 0, 0, 0);

    for (int i = 0; i < 22; i++) begin
      string nm;
      nm = $sformatf("row%0d", i);
      rst = tbl[i].rst; fetch_valid_i = tbl[i].fv; ex_start_i = tbl[i].exs;
      ex_cycles_i = tbl[i].cyc; branch_en_i = tbl[i].br; branch_addr_i = tbl[i].baddr;
      #1;
      chk({nm, "_valid"},  {29'h0, stage_valid_o}, {29'h0, tbl[i].ev});
      chk({nm, "_en"},     {29'h0, stage_en_o},    {29'h0, tbl[i].een});
      chk({nm, "_stall"},  {31'h0, stall_if_o},    {31'h0, tbl[i].est});
      chk({nm, "_hazard"}, {31'h0, hazard_o},      {31'h0, tbl[i].ehz});
      chk({nm, "_flush"},  {31'h0, flush_o},       {31'h0, tbl[i].efl});
      chk({nm, "_redir"},  {31'h0, redirect_o},    {31'h0, tbl[i].erd});
      pop_redirect(nm);
      if (tbl[i].rst && tbl[i].br && !tbl[i].est) exp_addr.push_back(tbl[i].baddr);
      tick();
    end

    raw_case(4'd3, 1'b0, 4'd3, 4'd0, 1'b1, 1'b0, FWD ? 0 : 1, "raw_rs");
    raw_case(4'd5, 1'b0, 4'd0, 4'd5, 1'b0, 1'b1, FWD ? 0 : 1, "raw_rd");
    raw_case(4'd3, 1'b0, 4'd3, 4'd3, 1'b0, 1'b0, 0,           "raw_unused");
    raw_case(4'd3, 1'b0, 4'd2, 4'd4, 1'b1, 1'b1, 0,           "raw_addr_diff");
    raw_case(4'd0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, FWD ? 0 : 1, "raw_r0");
    raw_case(4'd7, 1'b1, 4'd7, 4'd0, 1'b1, 1'b0, 1,           "load_use");

    // Branch resolving in the same cycle as a load-use hazard.
    do_reset();
    fetch_valid_i = 1'b1;
    tick();
    id_wb_en_i = 1'b1; id_ld_i = 1'b1; id_rd_addr_i = 4'd3;
    tick();
    id_wb_en_i = 1'b0; id_ld_i = 1'b0; id_rs_addr_i = 4'd3; id_use_rs_i = 1'b1;
    branch_en_i = 1'b1; branch_addr_i = 16'h00AA;
    #1;
    chk("brhz_stall",  {31'h0, stall_if_o}, 32'h0);
    chk("brhz_hazard", {31'h0, hazard_o},   32'h0);
    chk("brhz_en",     {29'h0, stage_en_o}, 32'h7);
    exp_addr.push_back(16'h00AA);
    tick();
    branch_en_i = 1'b0; id_use_rs_i = 1'b0;
    #1;
    chk("brhz_flush", {31'h0, flush_o},       32'h1);
    chk("brhz_redir", {31'h0, redirect_o},    32'h1);
    chk("brhz_valid", {29'h0, stage_valid_o}, 32'h4);
    pop_redirect("brhz");
    tick();
    chk("brhz_flush_pulse", {31'h0, flush_o},    32'h0);
    chk("brhz_redir_pulse", {31'h0, redirect_o}, 32'h0);

    // Reset while the busy counter holds 2.
    do_reset();
    fetch_valid_i = 1'b1;
    tick();
    tick();
    ex_start_i = 1'b1; ex_cycles_i = 4'd3;
    tick();
    ex_start_i = 1'b0; ex_cycles_i = 4'd0;
    #1;
    chk("busyrst_stall3", {31'h0, stall_if_o}, 32'h1);
    tick();
    chk("busyrst_stall2", {31'h0, stall_if_o}, 32'h1);
    rst = 1'b0; branch_en_i = 1'b1; branch_addr_i = 16'h0BAD;
    tick();
    rst = 1'b1; branch_en_i = 1'b0; fetch_valid_i = 1'b0;
    #1;
    chk("busyrst_valid", {29'h0, stage_valid_o}, 32'h0);
    chk("busyrst_stall", {31'h0, stall_if_o},    32'h0);
    chk("busyrst_flush", {31'h0, flush_o},       32'h0);
    chk("busyrst_redir", {31'h0, redirect_o},    32'h0);
    tick();
    chk("busyrst_stall_after", {31'h0, stall_if_o}, 32'h0);
    chk("busyrst_redir_after", {31'h0, redirect_o}, 32'h0);

    // Reset in the same cycle a branch would be taken.
    do_reset();
    fetch_valid_i = 1'b1;
    tick();
    tick();
    rst = 1'b0; branch_en_i = 1'b1; branch_addr_i = 16'h0CC0;
    tick();
    rst = 1'b1; branch_en_i = 1'b0;
    #1;
    chk("flushrst_flush", {31'h0, flush_o},           32'h0);
    chk("flushrst_redir", {31'h0, redirect_o},        32'h0);
    chk("flushrst_addr",  {16'h0, redirect_addr_o},   32'h0);

    chk("addr_queue_empty", exp_addr.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
